icache_refill_ctrl: RTL

- Control stage directly upstream of the single-line instruction cache array (`icache_one_line`).
- Accepts CPU fetch requests and runs a lookup on the line array (compare + read).
- On hit, returns the 32-bit word. On miss, fetches the 256-bit line from memory as 8 word beats, writes the assembled line into the array, then returns the critical word from the fill buffer.

---
 rtl/icache_pkg.sv | 35 +++
 rtl/icache_refill_ctrl_if.sv | 43 ++++
 rtl/icache_fill_buf.sv | 40 ++++
 rtl/icache_refill_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, address field helpers and FSM state type for the icache refill controller.
// Latency: none (package only).
// Backpressure: n/a.
package icache_pkg;

    localparam int ADDR_W = 32;
    localparam int TAG_W  = 19;
    localparam int IDX_W  = 8;
    localparam int OFF_W  = 5;
    localparam int LINE_W = 256;
    localparam int WORDS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        HIT_RESP,
        FILL,
        WRITE,
        MISS_RESP
    } state_t;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    // Word within the line; the two byte-offset bits are dropped.
    function automatic logic [OFF_W-3:0] word_of(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:2];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bundles the CPU fetch, line-array and refill-memory signals of the refill controller.
// Latency: none (wiring only).
// Backpressure: cpu side via cpu_busy, memory side via mem_req/mem_ack.
interface icache_refill_ctrl_if;
    import icache_pkg::*;

    logic                  cpu_req;
    logic [ADDR_W-1:0]     cpu_addr;
    logic                  cpu_busy;
    logic                  cpu_rvalid;
    logic [31:0]           cpu_rdata;

    logic                  line_enable;
    logic                  line_compare;
    logic                  line_read;
    logic [ADDR_W-1:0]     line_addr;
    logic [LINE_W-1:0]     line_data;
    logic                  line_hit;
    logic                  line_valid;
    logic [31:0]           line_rdata;

    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    // Controller side.
    modport master (
        input  cpu_req, cpu_addr, line_hit, line_valid, line_rdata, mem_ack, mem_rdata,
        output cpu_busy, cpu_rvalid, cpu_rdata,
               line_enable, line_compare, line_read, line_addr, line_data,
               mem_req, mem_addr
    );

    // CPU, line array and memory side.
    modport slave (
        output cpu_req, cpu_addr, line_hit, line_valid, line_rdata, mem_ack, mem_rdata,
        input  cpu_busy, cpu_rvalid, cpu_rdata,
               line_enable, line_compare, line_read, line_addr, line_data,
               mem_req, mem_addr
    );

endinterface

// File: rtl/icache_fill_buf.sv
// Eight-word refill buffer: beat-indexed writes, flat line view and one word-select read port.
// Latency: write visible on outputs the cycle after wr_en; reads are combinational.
// Backpressure: none; the caller only writes on an accepted memory beat.
module icache_fill_buf
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_idx,
    input  logic [31:0]       wr_dat,
    input  logic [2:0]        rd_idx,
    output logic [31:0]       rd_dat,
    output logic [LINE_W-1:0] line_dat
);

    // Element k sits at bits [32k+31:32k] of the flat line.
    logic [WORDS-1:0][31:0] words_q, words_d;

    // Next-state: overwrite only the addressed word.
    always_comb begin
        words_d = words_q;
        if (wr_en) begin
            words_d[wr_idx] = wr_dat;
        end
    end

    // Word storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign line_dat = words_q;
    assign rd_dat   = words_q[rd_idx];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch control in front of a single-line icache: lookup, 8-beat refill, line write, word return.
// Latency: hit 2 cycles from request acceptance; miss 11 cycles plus any mem_ack stall cycles.
// Backpressure: cpu_busy outside IDLE (requests dropped, not queued); mem_req held until mem_ack.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    icache_refill_ctrl_if.master bus,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          beat_q, beat_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [LINE_W-1:0]   line_data_q, line_data_d;

    logic                buf_we;
    logic [31:0]         buf_word;
    logic [LINE_W-1:0]   buf_line;

    logic                cpu_rvalid, line_enable, line_compare, line_read, mem_req;
    logic [31:0]         cpu_rdata;
    logic [ADDR_W-1:0]   mem_addr;

    icache_fill_buf u_fill_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (buf_we),
        .wr_idx   (beat_q),
        .wr_dat   (bus.mem_rdata),
        .rd_idx   (word_of(addr_q)),
        .rd_dat   (buf_word),
        .line_dat (buf_line)
    );

    // Next-state and outputs; line_addr/line_data fall back to their last driven values.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        buf_we       = 1'b0;
        cpu_rvalid   = 1'b0;
        cpu_rdata    = '0;
        line_enable  = 1'b0;
        line_compare = 1'b0;
        line_read    = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                line_enable  = 1'b1;
                line_compare = 1'b1;
                line_read    = 1'b1;
                line_addr_d  = addr_q;
                if (bus.line_hit && bus.line_valid) begin
                    hit_cnt_d = hit_cnt_q + 1'b1;
                    state_d   = HIT_RESP;
                end else begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                    beat_d     = '0;
                    state_d    = FILL;
                end
            end
            HIT_RESP: begin
                // The array registered the word on the LOOKUP edge.
                cpu_rvalid = 1'b1;
                cpu_rdata  = bus.line_rdata;
                state_d    = IDLE;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_of(addr_q), idx_of(addr_q), beat_q, 2'b00};
                if (bus.mem_ack) begin
                    buf_we = 1'b1;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'(WORDS - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                line_enable = 1'b1;
                line_addr_d = addr_q;
                line_data_d = buf_line;
                state_d     = MISS_RESP;
            end
            MISS_RESP: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = buf_word;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request context, counters and held line-array outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
        end
    end

    assign bus.cpu_busy     = (state_q != IDLE);
    assign bus.cpu_rvalid   = cpu_rvalid;
    assign bus.cpu_rdata    = cpu_rdata;
    assign bus.line_enable  = line_enable;
    assign bus.line_compare = line_compare;
    assign bus.line_read    = line_read;
    assign bus.line_addr    = line_addr_d;
    assign bus.line_data    = line_data_d;
    assign bus.mem_req      = mem_req;
    assign bus.mem_addr     = mem_addr;
    assign hit_cnt          = hit_cnt_q;
    assign miss_cnt         = miss_cnt_q;

endmodule
